// File: rtl/basic_source_pkg.sv
// Shared types for the basic_source producer: section encoding, widths and the
// word-advance helper.
package basic_source_types;

  localparam int DATA_W  = 32;
  localparam int TOTAL_W = 32;

  typedef enum logic {
    idle = 1'b0,
    send = 1'b1
  } sections_t;

  // Two's-complement advance; wraps silently at the 32-bit boundary.
  function automatic logic [DATA_W-1:0] next_word(input logic [DATA_W-1:0] w,
                                                  input int step);
    return w + DATA_W'(step);
  endfunction

endpackage

// File: rtl/basic_source_step_counter.sv
// Remaining-words counter with last-word detect; load wins over decrement.
// Zero latency on last, counter updates one edge after load/dec.
module basic_source_step_counter #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [COUNT_W-1:0] load_val,
  input  logic               dec,
  output logic [COUNT_W-1:0] count,
  output logic               last
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec) begin
      count <= count - COUNT_W'(1);
    end
  end

  assign last = (count == COUNT_W'(1));

endmodule

// File: rtl/basic_source.sv
// Emits cmd_count words cmd_start, +STEP, ... one per b_out handshake; first word offered
// the cycle after the command edge. Stalls on b_out_sync low; commands held off while sending.
module basic_source
  import basic_source_types::*;
#(
  parameter int STEP    = 1,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        cmd_start,
  input  logic [COUNT_W-1:0] cmd_count,
  input  logic               cmd_sync,
  output logic               cmd_notify,
  output logic [31:0]        b_out,
  input  logic               b_out_sync,
  output logic               b_out_notify,
  output logic               busy,
  output logic [31:0]        sent_total
);

  sections_t           section_q, section_d;
  logic [DATA_W-1:0]   b_out_q, b_out_d;
  logic [TOTAL_W-1:0]  sent_total_q, sent_total_d;
  logic [COUNT_W-1:0]  remaining;
  logic                last_word;
  logic                cnt_load, cnt_dec;
  logic                cmd_xfer, out_xfer;

  // Notifies depend only on the section register, never on a sync input.
  assign cmd_notify   = (section_q == idle);
  assign b_out_notify = (section_q == send);
  assign busy         = (section_q == send);
  assign b_out        = b_out_q;
  assign sent_total   = sent_total_q;

  assign cmd_xfer = cmd_sync && cmd_notify;
  assign out_xfer = b_out_sync && b_out_notify;

  basic_source_step_counter #(
    .COUNT_W (COUNT_W)
  ) u_step_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cmd_count),
    .dec      (cnt_dec),
    .count    (remaining),
    .last     (last_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      section_q    <= idle;
      b_out_q      <= '0;
      sent_total_q <= '0;
    end else begin
      section_q    <= section_d;
      b_out_q      <= b_out_d;
      sent_total_q <= sent_total_d;
    end
  end

  always_comb begin
    section_d    = section_q;
    b_out_d      = b_out_q;
    sent_total_d = sent_total_q;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    case (section_q)
      idle: begin
        // A zero-count command is consumed without leaving idle.
        if (cmd_xfer && (cmd_count != '0)) begin
          b_out_d   = cmd_start;
          cnt_load  = 1'b1;
          section_d = send;
        end
      end
      send: begin
        if (out_xfer) begin
          sent_total_d = sent_total_q + TOTAL_W'(1);
          cnt_dec      = 1'b1;
          if (last_word) begin
            section_d = idle;
          end else begin
            b_out_d = next_word(b_out_q, STEP);
          end
        end
      end
      default: section_d = idle;
    endcase
  end

endmodule

// File: tb/tb_basic_source.sv
// Directed bench for basic_source: reset, bursts, stalls, zero count, wrap,
// command held off during send, and reset mid-burst.
module tb_basic_source;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] cmd_start = '0;
  logic [15:0] cmd_count = '0;
  logic        cmd_sync = 1'b0;
  logic        cmd_notify;
  logic [31:0] b_out;
  logic        b_out_sync = 1'b0;
  logic        b_out_notify;
  logic        busy;
  logic [31:0] sent_total;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  basic_source #(.STEP(1), .COUNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_start    (cmd_start),
    .cmd_count    (cmd_count),
    .cmd_sync     (cmd_sync),
    .cmd_notify   (cmd_notify),
    .b_out        (b_out),
    .b_out_sync   (b_out_sync),
    .b_out_notify (b_out_notify),
    .busy         (busy),
    .sent_total   (sent_total)
  );

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if (cmd_notify !== 1'b1) begin n_bad++; $display("FAIL reset_cmd_notify got %b exp 1", cmd_notify); end
    n_cmp++; if (b_out_notify !== 1'b0) begin n_bad++; $display("FAIL reset_b_out_notify got %b exp 0", b_out_notify); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_cmp++; if (sent_total !== 32'd0) begin n_bad++; $display("FAIL reset_sent_total got %0d exp 0", sent_total); end
    n_cmp++; if (b_out !== 32'd0) begin n_bad++; $display("FAIL reset_b_out got %h exp 0", b_out); end
  endtask

  task automatic test_basic_burst();
    cmd_start = 32'd10; cmd_count = 16'd3; cmd_sync = 1'b1; b_out_sync = 1'b1;
    step();
    cmd_sync = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL burst_busy got %b exp 1", busy); end
    n_cmp++; if (cmd_notify !== 1'b0) begin n_bad++; $display("FAIL burst_cmd_notify got %b exp 0", cmd_notify); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (b_out_notify !== 1'b1 || b_out !== 32'(10 + i)) begin
        n_bad++; $display("FAIL burst_word%0d got notify=%b data=%0d exp notify=1 data=%0d", i, b_out_notify, b_out, 10 + i);
      end
      step();
    end
    n_cmp++; if (b_out_notify !== 1'b0) begin n_bad++; $display("FAIL burst_end_notify got %b exp 0", b_out_notify); end
    n_cmp++; if (cmd_notify !== 1'b1) begin n_bad++; $display("FAIL burst_end_cmd_notify got %b exp 1", cmd_notify); end
    n_cmp++; if (sent_total !== 32'd3) begin n_bad++; $display("FAIL burst_sent_total got %0d exp 3", sent_total); end
    n_cmp++; if (b_out !== 32'd12) begin n_bad++; $display("FAIL burst_last_held got %0d exp 12", b_out); end
    b_out_sync = 1'b0;
  endtask

  task automatic test_backpressure();
    cmd_start = 32'd5; cmd_count = 16'd2; cmd_sync = 1'b1; b_out_sync = 1'b0;
    step();
    cmd_sync = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (b_out_notify !== 1'b1 || b_out !== 32'd5) begin
        n_bad++; $display("FAIL stall%0d got notify=%b data=%0d exp notify=1 data=5", i, b_out_notify, b_out);
      end
      step();
    end
    n_cmp++; if (sent_total !== 32'd3) begin n_bad++; $display("FAIL stall_total got %0d exp 3", sent_total); end
    b_out_sync = 1'b1;
    n_cmp++; if (b_out !== 32'd5) begin n_bad++; $display("FAIL bp_word0 got %0d exp 5", b_out); end
    step();
    n_cmp++; if (b_out !== 32'd6 || b_out_notify !== 1'b1) begin n_bad++; $display("FAIL bp_word1 got data=%0d notify=%b exp data=6 notify=1", b_out, b_out_notify); end
    step();
    n_cmp++; if (b_out_notify !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL bp_end got notify=%b busy=%b exp 0 0", b_out_notify, busy); end
    n_cmp++; if (sent_total !== 32'd5) begin n_bad++; $display("FAIL bp_total got %0d exp 5", sent_total); end
    b_out_sync = 1'b0;
  endtask

  task automatic test_zero_and_wrap();
    cmd_start = 32'd77; cmd_count = 16'd0; cmd_sync = 1'b1;
    step();
    cmd_sync = 1'b0;
    n_cmp++; if (b_out_notify !== 1'b0 || busy !== 1'b0 || cmd_notify !== 1'b1) begin
      n_bad++; $display("FAIL zero_count got notify=%b busy=%b cmd_notify=%b exp 0 0 1", b_out_notify, busy, cmd_notify);
    end
    step();
    n_cmp++; if (b_out_notify !== 1'b0 || sent_total !== 32'd5) begin
      n_bad++; $display("FAIL zero_count_after got notify=%b total=%0d exp 0 5", b_out_notify, sent_total);
    end
    cmd_start = 32'h7FFF_FFFF; cmd_count = 16'd2; cmd_sync = 1'b1; b_out_sync = 1'b1;
    step();
    cmd_sync = 1'b0;
    n_cmp++; if (b_out !== 32'h7FFF_FFFF) begin n_bad++; $display("FAIL wrap_word0 got %h exp 7fffffff", b_out); end
    step();
    n_cmp++; if (b_out !== 32'h8000_0000 || b_out_notify !== 1'b1) begin n_bad++; $display("FAIL wrap_word1 got %h notify=%b exp 80000000 1", b_out, b_out_notify); end
    step();
    n_cmp++; if (b_out_notify !== 1'b0 || sent_total !== 32'd7) begin n_bad++; $display("FAIL wrap_end got notify=%b total=%0d exp 0 7", b_out_notify, sent_total); end
    b_out_sync = 1'b0;
  endtask

  task automatic test_cmd_during_send();
    cmd_start = 32'd100; cmd_count = 16'd3; cmd_sync = 1'b1; b_out_sync = 1'b0;
    step();
    cmd_start = 32'd200; cmd_count = 16'd2;
    step();
    step();
    n_cmp++; if (b_out !== 32'd100 || busy !== 1'b1 || cmd_notify !== 1'b0) begin
      n_bad++; $display("FAIL pend_ignored got data=%0d busy=%b cmd_notify=%b exp 100 1 0", b_out, busy, cmd_notify);
    end
    b_out_sync = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (b_out !== 32'(100 + i)) begin n_bad++; $display("FAIL pend_first%0d got %0d exp %0d", i, b_out, 100 + i); end
      step();
    end
    n_cmp++; if (cmd_notify !== 1'b1 || b_out_notify !== 1'b0) begin
      n_bad++; $display("FAIL pend_turnaround got cmd_notify=%b notify=%b exp 1 0", cmd_notify, b_out_notify);
    end
    step();
    cmd_sync = 1'b0;
    n_cmp++; if (b_out !== 32'd200 || busy !== 1'b1) begin n_bad++; $display("FAIL pend_restart got data=%0d busy=%b exp 200 1", b_out, busy); end
    step();
    n_cmp++; if (b_out !== 32'd201) begin n_bad++; $display("FAIL pend_second got %0d exp 201", b_out); end
    step();
    step();
    step();
    n_cmp++; if (b_out_notify !== 1'b0 || sent_total !== 32'd12) begin
      n_bad++; $display("FAIL pend_once got notify=%b total=%0d exp 0 12", b_out_notify, sent_total);
    end
    b_out_sync = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    cmd_start = 32'd50; cmd_count = 16'd5; cmd_sync = 1'b1; b_out_sync = 1'b1;
    step();
    cmd_sync = 1'b0;
    step();
    n_cmp++; if (b_out !== 32'd51 || b_out_notify !== 1'b1) begin n_bad++; $display("FAIL mid_second got %0d notify=%b exp 51 1", b_out, b_out_notify); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if (b_out_notify !== 1'b0 || busy !== 1'b0 || cmd_notify !== 1'b1) begin
      n_bad++; $display("FAIL mid_reset got notify=%b busy=%b cmd_notify=%b exp 0 0 1", b_out_notify, busy, cmd_notify);
    end
    n_cmp++; if (sent_total !== 32'd0 || b_out !== 32'd0) begin n_bad++; $display("FAIL mid_reset_regs got total=%0d data=%0d exp 0 0", sent_total, b_out); end
    step();
    step();
    n_cmp++; if (b_out_notify !== 1'b0 || sent_total !== 32'd0) begin n_bad++; $display("FAIL mid_quiet got notify=%b total=%0d exp 0 0", b_out_notify, sent_total); end
    b_out_sync = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_burst();
    test_backpressure();
    test_zero_and_wrap();
    test_cmd_during_send();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
